jtag_cmd_phy: RTL and testbench
===============================

// Module: jtag_cmd_phy
// PURPOSE
//  Downstream stage of the host<->JTAG converter: pops packed JTAG commands from the converter's
//  command FIFO and drives TCK/TMS/TDI to the target pins. It captures TDO and pushes 32-bit
//  responses into the response FIFO that the converter drains. Bit-level engine only; no TAP-state tracking.
// PARAMETERS
//  CLK_DIV   4   CLK cycles per TCK half-period (>=1); TCK = CLK/(2*CLK_DIV)
// PORTS
//  CLK          in   1   system clock
//  RESET        in   1   synchronous, active-high reset
//  CMD_RDDATA   in   40  command word (jtag_phy_pkg::cmd_t), first-word-fall-through
//  CMD_RDEMPTY  in   1   command FIFO empty
//  CMD_RDEN     out  1   pop command (1-cycle pulse)
//  RESP_WRDATA  out  32  captured TDO, right-aligned, bit0 = first bit shifted
//  RESP_WREN    out  1   push response (1-cycle pulse)
//  RESP_WRFULL  in   1   response FIFO full
//  TCK          out  1   JTAG clock
//  TMS          out  1   JTAG mode select
//  TDI          out  1   JTAG data to target
//  TDO          in   1   JTAG data from target (pre-synchronised by pad logic)
//  BUSY         out  1   high while a command is executing
// BEHAVIOUR
//  cmd_t = {op[1:0], len[4:0], tms_last, data[31:0]}; nbits = len+1 (1..32); all shifts are LSB first.
//  Ops: TMS_SEQ(0) TMS=data[i], TDI=0, no response; SHIFT_WR(1) TDI=data[i], TMS=0 (last bit: tms_last),
//   no response; SHIFT_RD(2) same as SHIFT_WR plus TDO capture and a response push; op 3 is a NOP:
//   popped and discarded, no pin activity.
//  Reset: TCK=0, TMS=1, TDI=0, CMD_RDEN=0, RESP_WREN=0, RESP_WRDATA=0, BUSY=0, FSM=IDLE.
//  FSM IDLE: when !CMD_RDEMPTY, and !(op==SHIFT_RD && RESP_WRFULL), pulse CMD_RDEN, latch word, go LO.
//   A SHIFT_RD with RESP_WRFULL=1 waits in IDLE; it is not popped.
//  LO: TCK=0, TMS/TDI set for bit i on entry (falling edge); hold CLK_DIV cycles -> HI.
//  HI: TCK=1; TDO sampled into resp[i] on the CLK edge where TCK rises; hold CLK_DIV cycles.
//   If i<nbits-1: i++, go to LO. Otherwise TCK->0 and go to RESP (SHIFT_RD) or IDLE.
//  RESP: one cycle, RESP_WREN=1, RESP_WRDATA = capture with bits >= nbits zeroed; next state IDLE.
//  Latency: pop -> first TCK rise = CLK_DIV+1 cycles. Command duration = 2*CLK_DIV*nbits cycles.
//   Back-to-back commands have 1 IDLE cycle between them, so TCK stays low for CLK_DIV+1 cycles.
//  TMS/TDI hold their last value between commands. BUSY=1 from the pop cycle through RESP/last HI.
//  RESET mid-command aborts immediately: no response is pushed, and the popped command is lost.
//  Bit counter is 5 bits; len=31 must shift exactly 32 bits with no wrap to 0.
// CONFIGURATION
//  JTAG_RTCK_EN defined: adds input port RTCK (1 bit), passed through a 2-flop synchroniser.
//   LO->HI and HI->LO wait until the synced RTCK equals the current TCK, in addition to CLK_DIV.
//   The RTCK wait has no timeout.
//  JTAG_RTCK_EN undefined: no RTCK port; timing is set by CLK_DIV alone.
// STRUCTURE
//  jtag_phy_pkg: op_t enum, cmd_t packed struct, CMD_W=40, RESP_W=32.
//  Sub-module jtag_tck_gen holds the half-period counter and the RTCK synchroniser/compare.
//   It outputs a phase_done strobe; the top holds the FSM, bit counter and shift registers.
// TESTING
//  CLK_DIV=2: TMS_SEQ len=4 data=0x1F -> 5 TCK pulses, TMS=1 on each rise, TDI=0, no RESP_WREN.
//  CLK_DIV=2: SHIFT_RD len=7 data=0xA5 tms_last=1, TDO model loopbacks TDI -> RESP_WRDATA=0x000000A5;
//   TMS=1 on the 8th rise only.
//  SHIFT_RD len=31, TDO model returns 0xDEADBEEF -> 32 TCK pulses, RESP_WRDATA=0xDEADBEEF.
//  SHIFT_RD queued with RESP_WRFULL=1 for 20 cycles -> CMD_RDEN stays 0, TCK idle.
//   Release -> pop occurs on the next cycle.
//  Two SHIFT_WR commands back-to-back, CLK_DIV=1 -> TCK low gap between commands = 2 CLK cycles.
//  RESET asserted at bit 3 of a SHIFT_RD -> next cycle TCK=0, TMS=1, BUSY=0, no RESP_WREN.

Source files
------------

// File: rtl/jtag_phy_pkg.sv
// Shared types for the JTAG command PHY: command word layout, op codes, FSM states.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package jtag_phy_pkg;

    localparam int CMD_W  = 40;
    localparam int RESP_W = 32;

    typedef enum logic [1:0] {
        OP_TMS_SEQ  = 2'd0,
        OP_SHIFT_WR = 2'd1,
        OP_SHIFT_RD = 2'd2,
        OP_NOP      = 2'd3
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [4:0]  len;       // number of bits minus one
        logic        tms_last;  // TMS on the final bit of a shift
        logic [31:0] data;      // shifted LSB first
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // {tms, tdi} to present for bit idx of a command
    function automatic logic [1:0] pin_bits(input cmd_t c, input logic [4:0] idx);
        logic tms;
        logic tdi;
        if (c.op == OP_TMS_SEQ) begin
            tms = c.data[idx];
            tdi = 1'b0;
        end else begin
            tdi = c.data[idx];
            tms = (idx == c.len) ? c.tms_last : 1'b0;
        end
        return {tms, tdi};
    endfunction

    // Ones in bit positions 0..len, zeros above
    function automatic logic [RESP_W-1:0] len_mask(input logic [4:0] len);
        return {RESP_W{1'b1}} >> (5'd31 - len);
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK half-period timer: strobes phase_done when the current TCK phase may end.
// Latency: phase_done after CLK_DIV cycles of run (plus RTCK echo wait when JTAG_RTCK_EN is defined).
// Backpressure: none; with JTAG_RTCK_EN the strobe is held off until the synced RTCK matches TCK.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
`ifdef JTAG_RTCK_EN
    input  logic tck,
    input  logic rtck,
`endif
    output logic phase_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             cnt_last;
    logic             edge_ok;

    assign cnt_last = (cnt_q == CNT_LAST);

`ifdef JTAG_RTCK_EN
    logic [1:0] rtck_sync_q;

    // Two-flop synchroniser for the returned clock
    always_ff @(posedge clk) begin
        if (reset) begin
            rtck_sync_q <= 2'b00;
        end else begin
            rtck_sync_q <= {rtck_sync_q[0], rtck};
        end
    end

    // Target must have echoed the current TCK level before the phase can end
    assign edge_ok = (rtck_sync_q[1] == tck);
`else
    assign edge_ok = 1'b1;
`endif

    assign phase_done = run && cnt_last && edge_ok;

    // Count cycles within a phase; saturate while waiting on RTCK, restart on each phase
    always_ff @(posedge clk) begin
        if (reset || !run || phase_done) begin
            cnt_q <= '0;
        end else if (!cnt_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_cmd_phy.sv
// JTAG bit engine: pops cmd_t words, drives TCK/TMS/TDI LSB first, pushes captured TDO for SHIFT_RD.
// Latency: pop to first TCK rise CLK_DIV+1 cycles; command takes 2*CLK_DIV*nbits cycles (+1 RESP cycle).
// Backpressure: a SHIFT_RD is not popped while RESP_WRFULL is high; JTAG_RTCK_EN adds an RTCK port and echo wait.
module jtag_cmd_phy
    import jtag_phy_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [CMD_W-1:0]  CMD_RDDATA,
    input  logic              CMD_RDEMPTY,
    output logic              CMD_RDEN,
    output logic [RESP_W-1:0] RESP_WRDATA,
    output logic              RESP_WREN,
    input  logic              RESP_WRFULL,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO,
`ifdef JTAG_RTCK_EN
    input  logic              RTCK,
`endif
    output logic              BUSY
);

    state_t            state_q;
    state_t            state_d;
    cmd_t              cmd_in;
    cmd_t              cmd_q;
    logic [4:0]        bit_q;
    logic [RESP_W-1:0] cap_q;
    logic [RESP_W-1:0] resp_q;
    logic              tck_q;
    logic              tms_q;
    logic              tdi_q;
    logic              pop;
    logic              run;
    logic              phase_done;
    logic              last_bit;

    assign cmd_in   = cmd_t'(CMD_RDDATA);
    assign run      = (state_q == ST_LO) || (state_q == ST_HI);
    // 5-bit counter reaches len (max 31) without wrapping, so len=31 gives 32 bits
    assign last_bit = (bit_q == cmd_q.len);

    jtag_tck_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_tck_gen (
        .clk        (CLK),
        .reset      (RESET),
        .run        (run),
`ifdef JTAG_RTCK_EN
        .tck        (tck_q),
        .rtck       (RTCK),
`endif
        .phase_done (phase_done)
    );

    // Next-state and pop decision
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!CMD_RDEMPTY && !(cmd_in.op == OP_SHIFT_RD && RESP_WRFULL)) begin
                    pop = 1'b1;
                    // NOP words are consumed with no pin activity
                    if (cmd_in.op != OP_NOP) begin
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (phase_done) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (phase_done) begin
                    if (!last_bit) begin
                        state_d = ST_LO;
                    end else if (cmd_q.op == OP_SHIFT_RD) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any command in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, bit counter, pin registers and TDO capture
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_q  <= '0;
            bit_q  <= 5'd0;
            cap_q  <= '0;
            resp_q <= '0;
            tck_q  <= 1'b0;
            tms_q  <= 1'b1;
            tdi_q  <= 1'b0;
        end else begin
            if (pop && cmd_in.op != OP_NOP) begin
                cmd_q          <= cmd_in;
                bit_q          <= 5'd0;
                cap_q          <= '0;
                {tms_q, tdi_q} <= pin_bits(cmd_in, 5'd0);
            end
            if (state_q == ST_LO && phase_done) begin
                tck_q        <= 1'b1;
                cap_q[bit_q] <= TDO;
            end
            if (state_q == ST_HI && phase_done) begin
                tck_q <= 1'b0;
                if (!last_bit) begin
                    bit_q          <= bit_q + 5'd1;
                    {tms_q, tdi_q} <= pin_bits(cmd_q, bit_q + 5'd1);
                end else if (cmd_q.op == OP_SHIFT_RD) begin
                    resp_q <= cap_q & len_mask(cmd_q.len);
                end
            end
        end
    end

    assign CMD_RDEN    = pop && !RESET;
    assign RESP_WREN   = (state_q == ST_RESP);
    assign RESP_WRDATA = resp_q;
    assign TCK         = tck_q;
    assign TMS         = tms_q;
    assign TDI         = tdi_q;
    assign BUSY        = (state_q != ST_IDLE) || CMD_RDEN;

endmodule

// File: tb/tb_jtag_cmd_phy.sv
// Scoreboard bench for jtag_cmd_phy: CLK_DIV=2 instance for most tests, CLK_DIV=1 for back-to-back gap.
// Expected pin values per TCK rise and expected responses are queued by the stimulus and popped by monitors.
// All waits are cycle-bounded.
module tb_jtag_cmd_phy;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // ---------------- CLK_DIV=2 instance ----------------
    logic [39:0] cmd_mem [0:63];
    logic [5:0]  rd_ptr = 6'd0;
    logic [5:0]  wr_ptr = 6'd0;
    logic [39:0] cmd_data;
    logic        cmd_empty;
    logic        cmd_rden;
    logic [31:0] resp_data;
    logic        resp_wren;
    logic        resp_full;
    logic        tck, tms, tdi, tdo, busy;

    logic        tdo_loop;
    logic [31:0] tdo_pat;
    int          tdo_base;
    int          rise_cnt = 0;
    logic [4:0]  tdo_sel;

    assign cmd_data  = cmd_mem[rd_ptr];
    assign cmd_empty = (rd_ptr == wr_ptr);
    assign tdo_sel   = 5'(rise_cnt - tdo_base);
    assign tdo       = tdo_loop ? tdi : tdo_pat[tdo_sel];

    always @(posedge clk) if (cmd_rden) rd_ptr <= rd_ptr + 6'd1;

    jtag_cmd_phy #(.CLK_DIV(2)) dut (
        .CLK         (clk),
        .RESET       (rst),
        .CMD_RDDATA  (cmd_data),
        .CMD_RDEMPTY (cmd_empty),
        .CMD_RDEN    (cmd_rden),
        .RESP_WRDATA (resp_data),
        .RESP_WREN   (resp_wren),
        .RESP_WRFULL (resp_full),
        .TCK         (tck),
        .TMS         (tms),
        .TDI         (tdi),
        .TDO         (tdo),
        .BUSY        (busy)
    );

    // ---------------- CLK_DIV=1 instance ----------------
    logic [39:0] cmd1_mem [0:3];
    logic [2:0]  rd1_ptr = 3'd0;
    logic [2:0]  wr1_ptr = 3'd0;
    logic [39:0] cmd1_data;
    logic        cmd1_empty;
    logic        cmd1_rden;
    logic [31:0] resp1_data;
    logic        resp1_wren;
    logic        tck1, tms1, tdi1, busy1;
    int          rise1 = 0;
    int          gap1 = 0;
    int          wren1_seen = 0;
    logic        prev1 = 1'b0;

    assign cmd1_data  = cmd1_mem[rd1_ptr[1:0]];
    assign cmd1_empty = (rd1_ptr == wr1_ptr);

    always @(posedge clk) if (cmd1_rden) rd1_ptr <= rd1_ptr + 3'd1;

    jtag_cmd_phy #(.CLK_DIV(1)) dut1 (
        .CLK         (clk),
        .RESET       (rst),
        .CMD_RDDATA  (cmd1_data),
        .CMD_RDEMPTY (cmd1_empty),
        .CMD_RDEN    (cmd1_rden),
        .RESP_WRDATA (resp1_data),
        .RESP_WREN   (resp1_wren),
        .RESP_WRFULL (1'b0),
        .TCK         (tck1),
        .TMS         (tms1),
        .TDI         (tdi1),
        .TDO         (1'b0),
        .BUSY        (busy1)
    );

    // ---------------- scoreboard ----------------
    logic [1:0]  exp_pin  [$];
    logic [31:0] exp_resp [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [1:0] op, input logic [4:0] len,
                                       input logic tl, input logic [31:0] data);
        return {op, len, tl, data};
    endfunction

    task automatic push(input logic [39:0] w);
        cmd_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    // Queue the expected {TMS,TDI} at every TCK rise of a command
    task automatic exp_cmd(input logic [39:0] w);
        logic [1:0]  op;
        logic [4:0]  len;
        logic        tl;
        logic [31:0] d;
        op = w[39:38]; len = w[37:33]; tl = w[32]; d = w[31:0];
        for (int i = 0; i <= int'(len); i++) begin
            if (op == 2'd0) exp_pin.push_back({d[i], 1'b0});
            else            exp_pin.push_back({(i == int'(len)) ? tl : 1'b0, d[i]});
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (!busy && cmd_empty) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b empty=%b, required idle within 2000 cycles", name, busy, cmd_empty);
        end
        chk({name, "_pins_left"}, 32'(exp_pin.size()), 32'd0);
        chk({name, "_resp_left"}, 32'(exp_resp.size()), 32'd0);
    endtask

    // Monitor: compare pins at each TCK rise, responses at each push, and pop-to-rise latency
    int   cyc = 0;
    int   pop_cyc = 0;
    bit   first_pending = 0;
    logic prev_tck = 1'b0;
    always @(negedge clk) begin
        logic [1:0]  ep;
        logic [31:0] er;
        if (rst) begin
            prev_tck = tck;
            first_pending = 0;
        end else begin
            cyc++;
            if (cmd_rden && cmd_data[39:38] != 2'd3) begin
                pop_cyc = cyc;
                first_pending = 1;
            end
            if (tck && !prev_tck) begin
                rise_cnt++;
                if (first_pending) begin
                    chk("pop_to_first_rise", 32'(cyc - pop_cyc), 32'd3);
                    first_pending = 0;
                end
                if (exp_pin.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tck_rise: got rise with tms=%b tdi=%b, required none", tms, tdi);
                end else begin
                    ep = exp_pin.pop_front();
                    chk("tms_tdi_at_rise", {30'd0, tms, tdi}, {30'd0, ep});
                end
            end
            if (resp_wren) begin
                if (exp_resp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp_wren: got data %h, required no push", resp_data);
                end else begin
                    er = exp_resp.pop_front();
                    chk("resp_data", resp_data, er);
                end
            end
            prev_tck = tck;
        end
    end

    // Monitor for the CLK_DIV=1 instance: rise count, low gap after the first command, stray pushes
    always @(negedge clk) begin
        if (!rst) begin
            if (tck1 && !prev1) rise1++;
            if (rise1 == 3 && !tck1) gap1++;
            if (resp1_wren) wren1_seen++;
            prev1 = tck1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [39:0] w;
        int          r0;
        bit          ok;
        rst = 1'b1; resp_full = 1'b0; tdo_loop = 1'b1; tdo_pat = 32'd0; tdo_base = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tck", {31'd0, tck}, 32'd0);
        chk("rst_tms", {31'd0, tms}, 32'd1);
        chk("rst_tdi", {31'd0, tdi}, 32'd0);
        chk("rst_rden", {31'd0, cmd_rden}, 32'd0);
        chk("rst_wren", {31'd0, resp_wren}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);

        // TMS_SEQ len=4 data=0x1F: five rises, TMS=1, TDI=0, no response
        w = mk(2'd0, 5'd4, 1'b0, 32'h1F);
        exp_cmd(w); push(w);
        wait_idle("tms_seq");

        // SHIFT_RD len=7 0xA5 with loopback; TMS=1 on the 8th rise only
        tdo_loop = 1'b1;
        w = mk(2'd2, 5'd7, 1'b1, 32'hA5);
        exp_cmd(w); exp_resp.push_back(32'h0000_00A5); push(w);
        wait_idle("shift_rd8");

        // SHIFT_RD len=31, target returns 0xDEADBEEF
        tdo_loop = 1'b0; tdo_pat = 32'hDEAD_BEEF; tdo_base = rise_cnt; r0 = rise_cnt;
        w = mk(2'd2, 5'd31, 1'b0, 32'h1234_5678);
        exp_cmd(w); exp_resp.push_back(32'hDEAD_BEEF); push(w);
        wait_idle("shift_rd32");
        chk("rd32_rise_count", 32'(rise_cnt - r0), 32'd32);

        // Bits above nbits are zeroed in the response
        tdo_pat = 32'hFFFF_FFFF; tdo_base = rise_cnt;
        w = mk(2'd2, 5'd3, 1'b1, 32'h0);
        exp_cmd(w); exp_resp.push_back(32'h0000_000F); push(w);
        wait_idle("shift_rd_mask");

        // SHIFT_RD held off by a full response FIFO
        tdo_loop = 1'b1; resp_full = 1'b1;
        w = mk(2'd2, 5'd0, 1'b0, 32'h1);
        exp_cmd(w); exp_resp.push_back(32'h1); push(w);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("full_no_pop", {31'd0, cmd_rden}, 32'd0);
            chk("full_tck_idle", {31'd0, tck}, 32'd0);
        end
        @(posedge clk); #1 resp_full = 1'b0;
        @(negedge clk);
        chk("pop_after_release", {31'd0, cmd_rden}, 32'd1);
        wait_idle("full_release");

        // NOP is consumed with no pin activity
        r0 = rise_cnt;
        w = mk(2'd3, 5'd5, 1'b1, 32'hFFFF);
        push(w);
        wait_idle("nop");
        chk("nop_consumed", {26'd0, wr_ptr - rd_ptr}, 32'd0);
        chk("nop_no_rise", 32'(rise_cnt - r0), 32'd0);

        // Reset during bit 3 of a SHIFT_RD: abort, no response
        tdo_loop = 1'b1; r0 = rise_cnt;
        w = mk(2'd2, 5'd7, 1'b0, 32'hA5);
        for (int i = 0; i < 4; i++) exp_pin.push_back({1'b0, w[i]});
        push(w);
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (rise_cnt == r0 + 4) ok = 1;
        end
        chk("reach_bit3", {31'd0, ok}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_tck", {31'd0, tck}, 32'd0);
        chk("abort_tms", {31'd0, tms}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_wren", {31'd0, resp_wren}, 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_no_more_rise", 32'(rise_cnt - r0), 32'd4);
        chk("abort_pins_left", 32'(exp_pin.size()), 32'd0);
        chk("abort_resp_left", 32'(exp_resp.size()), 32'd0);

        // Back-to-back SHIFT_WR on the CLK_DIV=1 instance
        cmd1_mem[0] = mk(2'd1, 5'd2, 1'b0, 32'h5);
        cmd1_mem[1] = mk(2'd1, 5'd1, 1'b1, 32'h2);
        wr1_ptr = 3'd2;
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (!busy1 && cmd1_empty) ok = 1;
        end
        chk("b2b_done", {31'd0, ok}, 32'd1);
        chk("b2b_gap", 32'(gap1), 32'd2);
        chk("b2b_rises", 32'(rise1), 32'd5);
        chk("b2b_no_resp", 32'(wren1_seen), 32'd0);
        chk("b2b_tms_hold", {31'd0, tms1}, 32'd1);
        chk("b2b_tdi_hold", {31'd0, tdi1}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
